// File: rtl/sx_demux.sv
// sx_demux: AXI-Stream 1:N packet demultiplexer with route lock and drop counting
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   s_axis_*           input stream; s_axis_id_i selects the output on a packet's first beat
//   m_axis_*           M_DATA_COUNT output streams fed from one registered beat buffer
//   drop_cnt_o         saturating count of packets whose ID matched no output
module sx_demux #(
  parameter int DATA_WIDTH   = 8,
  parameter int M_DATA_COUNT = 4,
  parameter int ID_WIDTH     = $clog2(M_DATA_COUNT)
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [DATA_WIDTH-1:0]                      s_axis_data_i,
  input  logic [ID_WIDTH-1:0]                        s_axis_id_i,
  input  logic                                       s_axis_last_i,
  input  logic                                       s_axis_valid_i,
  input  logic [DATA_WIDTH/8-1:0]                    s_axis_keep_i,
  output logic                                       s_axis_ready_o,
  output logic [M_DATA_COUNT-1:0][DATA_WIDTH-1:0]    m_axis_data_o,
  output logic [M_DATA_COUNT-1:0]                    m_axis_last_o,
  output logic [M_DATA_COUNT-1:0]                    m_axis_valid_o,
  output logic [M_DATA_COUNT-1:0][DATA_WIDTH/8-1:0]  m_axis_keep_o,
  input  logic [M_DATA_COUNT-1:0]                    m_axis_ready_i,
  output logic [15:0]                                drop_cnt_o
);
  typedef enum logic [1:0] {SM_IDLE, SM_TRANSIT, SM_DROP} state_t;
  state_t state, state_nx;
  logic [ID_WIDTH-1:0] dest_reg, route, out_dest;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DATA_WIDTH/8-1:0] out_keep;
  logic out_valid, out_last, route_ok, discard, drain, accept, load, drop_inc;
  assign route    = (state == SM_TRANSIT) ? dest_reg : s_axis_id_i;
  assign route_ok = {1'b0, route} < (ID_WIDTH+1)'(M_DATA_COUNT);
  // beats that will be thrown away never wait on the output buffer
  assign discard  = (state == SM_DROP) | ((state == SM_IDLE) & !route_ok);
  assign drain    = |(m_axis_valid_o & m_axis_ready_i);
  assign s_axis_ready_o = discard | !out_valid | drain;
  assign accept   = s_axis_valid_i & s_axis_ready_o;
  assign load     = accept & !discard;
  assign drop_inc = accept & discard & s_axis_last_i;
  for (genvar i = 0; i < M_DATA_COUNT; i++) begin : g_out
    assign m_axis_valid_o[i] = out_valid & (out_dest == ID_WIDTH'(i));
    assign m_axis_last_o[i]  = out_last & (out_dest == ID_WIDTH'(i));
    assign m_axis_data_o[i]  = out_data;
    assign m_axis_keep_o[i]  = out_keep;
  end
  always_comb begin
    state_nx = state;
    case (state)
      SM_IDLE:             if (accept && !s_axis_last_i) state_nx = route_ok ? SM_TRANSIT : SM_DROP;
      SM_TRANSIT, SM_DROP: if (accept && s_axis_last_i) state_nx = SM_IDLE;
      default:             state_nx = SM_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SM_IDLE;
      dest_reg   <= '0;
      out_valid  <= 1'b0;
      out_dest   <= '0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      state <= state_nx;
      if (state == SM_IDLE && load && !s_axis_last_i) dest_reg <= s_axis_id_i;
      // a new load wins over a drain so the buffer sustains one beat per clock
      if (load) begin
        out_valid <= 1'b1;
        out_dest  <= route;
        out_data  <= s_axis_data_i;
        out_keep  <= s_axis_keep_i;
        out_last  <= s_axis_last_i;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drop_inc && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
endmodule

// File: doc/sx_demux.md
Name: sx_demux

Overview:
Packet-routing AXI-Stream demultiplexer, the 1:N counterpart of the switch's N:1 input mux. It accepts one stream carrying a per-packet destination ID and steers each whole packet to one of M_DATA_COUNT output streams. The route is locked from the first beat of a packet until its last beat. Packets whose ID has no matching output are consumed and counted. One registered output stage gives 1-cycle latency at full throughput.

Parameters:
DATA_WIDTH, 8, data bus width in bits; must be a multiple of 8.
M_DATA_COUNT, 4, number of output streams; must be >= 2.
ID_WIDTH, $clog2(M_DATA_COUNT), width of the destination ID; may be set wider to allow out-of-range IDs.

Ports:
clk  in  1  clock.
reset_n  in  1  reset; asynchronous, active-low.
s_axis_data_i  in  DATA_WIDTH  input data.
s_axis_id_i  in  ID_WIDTH  destination output index; sampled on the first beat of a packet only.
s_axis_last_i  in  1  end of packet.
s_axis_valid_i  in  1  input valid.
s_axis_keep_i  in  DATA_WIDTH/8  byte enables.
s_axis_ready_o  out  1  input ready.
m_axis_data_o  out  [M_DATA_COUNT][DATA_WIDTH]  output data; the same register is driven to all outputs.
m_axis_last_o  out  [M_DATA_COUNT]  end of packet per output.
m_axis_valid_o  out  [M_DATA_COUNT]  valid per output; one-hot or zero.
m_axis_keep_o  out  [M_DATA_COUNT][DATA_WIDTH/8]  byte enables per output.
m_axis_ready_i  in  [M_DATA_COUNT]  ready per output.
drop_cnt_o  out  16  count of dropped packets; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, active-low)
  - State goes to SM_IDLE; output buffer is empty.
  - m_axis_valid_o = 0, m_axis_last_o = 0, m_axis_data_o = 0, m_axis_keep_o = 0.
  - drop_cnt_o = 0, dest_reg = 0.
  - Reset in the middle of a packet abandons it. The next accepted beat is treated as a first beat.
- Output buffer (single entry): registers out_valid, out_dest, out_data, out_keep, out_last.
  - m_axis_valid_o[i] = out_valid & (out_dest == i).
  - m_axis_last_o[i] = out_last & (out_dest == i).
  - m_axis_data_o and m_axis_keep_o are broadcast from the buffer; they are meaningful only where valid is high.
- Route selection
  - route = s_axis_id_i in SM_IDLE; route = dest_reg in SM_TRANSIT.
  - A route is invalid if it is >= M_DATA_COUNT.
- Ready
  - SM_DROP, or SM_IDLE with an invalid route: s_axis_ready_o = 1.
  - Otherwise: s_axis_ready_o = !out_valid | m_axis_ready_i[out_dest].
  - Ready is combinational; it depends on m_axis_ready_i and never on s_axis_valid_i.
- Accept condition: s_axis_valid_i & s_axis_ready_o.
  - A routed accepted beat loads the buffer with out_dest = route.
  - If the buffer drains in the same cycle, the load takes priority, giving back-to-back throughput of 1 beat/clk.
  - If the buffer drains with no load, out_valid goes to 0.
- Latency: a beat accepted at edge k appears on m_axis at k+1.
- State machine: SM_IDLE, SM_TRANSIT, SM_DROP.
  - SM_IDLE, routed accept, last=0: dest_reg <= s_axis_id_i; go to SM_TRANSIT.
  - SM_IDLE, routed accept, last=1: single-beat packet; stay in SM_IDLE.
  - SM_IDLE, invalid-route accept: the beat is discarded and the buffer is untouched.
    - last=1: drop_cnt_o increments; stay in SM_IDLE.
    - last=0: go to SM_DROP.
  - SM_TRANSIT: s_axis_id_i is ignored. An accept with last=1 goes to SM_IDLE.
  - SM_DROP: every beat is accepted and discarded. An accept with last=1 increments drop_cnt_o and goes to SM_IDLE.
  - Illegal state encoding goes to SM_IDLE.
- drop_cnt_o saturates at 16'hFFFF and never wraps.
- A packet bound for a different output while the buffer holds a beat for a stalled output waits. There is no bypass; head-of-line blocking is accepted.
- A stall on an idle output has no effect on the input.

Test Plan:
- M=4, DW=8, all m ready=1. Send 3-beat packet id=2, data 0x11,0x22,0x33 → m_axis_valid_o=4'b0100 for 3 consecutive cycles starting 1 cycle after the first accept; last is high with 0x33 only; s_axis_ready_o=1 throughout.
- Route lock: 4-beat packet, id=1 on beat 0, s_axis_id_i toggled to 3 on beats 1-3 → all 4 beats appear on output 1 only; output 3 stays idle.
- Backpressure: m_axis_ready_i[0]=0 for 5 cycles during a packet to id=0 → s_axis_ready_o=0 while the buffer is full; no beat is lost or duplicated; order is preserved; m_axis_ready_i[1]=0 has no effect.
- Back-to-back single-beat packets id=0,1,2,3,0 with valid held high → one beat per output per cycle in sequence; state stays SM_IDLE; no bubbles.
- Drop: M=3, ID_WIDTH=2. Send 2-beat packet id=3, then 1-beat packet id=3, then 1-beat packet id=1 → no m valid for the first two packets; drop_cnt_o=2; the third packet arrives on output 1.
- Reset mid-packet: reset_n low after beat 1 of a 4-beat packet to id=2 → all m valid=0 immediately; drop_cnt_o=0; the next beat with id=0 is routed to output 0.
